cp0_regs: RTL and testbench
===========================

# cp0_regs

Coprocessor-0 register file for the NaiveMIPS core; sits directly downstream of the MEM-stage exception unit and consumes its `cp0w` record. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and executes `mtc0`/`mfc0`/`eret` side effects and the architectural exception-entry update. It also runs the Count/Compare timer and feeds the pending-and-enabled interrupt vector back to the exception unit.

## Interface
Parameters: none (register numbers fixed: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14).
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- hw_int  input  6  external interrupt lines, level-sensitive, already synchronous to clk
- cp0w  input  reg_error  exception record: we, exc[4:0], bd, exl, epc[31:0], bva[31:0]
- eret  input  1  ERET retiring in MEM this cycle
- mtc0_we  input  1  MTC0 retiring this cycle
- mtc0_addr  input  5  destination CP0 register number
- mtc0_data  input  32  write data
- mfc0_addr  input  5  read register number
- mfc0_data  output  32  combinational read of current register state
- intr_vect  output  8  pending interrupts to exception unit
- epc_out  output  32  current EPC, ERET target
- status_out, cause_out  output  32  current Status / Cause

## Operation
- Status: bit22 BEV read-only 1; IM[15:8], EXL[1], IE[0] writable; all other bits read 0. Reset 0x0040_0000.
- Cause: BD[31], TI[30], IP[15:10] hardware, IP[9:8] software-writable, ExcCode[6:2]; others 0. Reset 0x0000_0000. MTC0 writes only IP[9:8].
- IP[15:10] each cycle loads {hw_int[5] | TI, hw_int[4:0]}.
- EPC, BadVAddr, Compare reset 0; Count reset 0. BadVAddr not MTC0-writable.
- Count increments by 1 every second cycle (internal tick flop, reset 0, toggles each cycle; increment when tick=1); wraps 0xFFFF_FFFF→0. MTC0 to Count loads data and clears tick.
- TI set when Count == Compare (Compare nonzero or not; compared after update); cleared by MTC0 to Compare; set has priority over nothing else.
- Exception entry (cp0w.we=1): ExcCode←exc; Status.EXL←1; if Status.EXL was 0: EPC←cp0w.epc, Cause.BD←cp0w.bd; if EXL was already 1, EPC and BD unchanged. BadVAddr←cp0w.bva only for exc 0x04 (AdEL) or 0x05 (AdES).
- ERET (eret=1, cp0w.we=0): Status.EXL←0.
- Priority per cycle: exception entry > ERET > MTC0. MTC0 and ERET in a cycle with cp0w.we=1 are discarded entirely; MTC0 with ERET: ERET applies, MTC0 discarded.
- intr_vect = (Status.IE & ~Status.EXL) ? (Cause.IP[15:8] & Status.IM) : 8'h00.
- mfc0_data: unimplemented register numbers return 0.

## Timing
- All state updates on posedge clk; rst clears asynchronously to values above regardless of clk.
- Reads (mfc0_data, intr_vect, epc_out, status/cause_out) combinational from registered state: MTC0 visible the cycle after the write edge; no internal bypass (pipeline forwards).
- hw_int to intr_vect: one cycle (sampled into Cause.IP then gated).
- Count==Compare to intr_vect[7]: TI set at the edge after equality; visible next cycle if IM7 & IE & ~EXL.
- ERET target: epc_out valid same cycle ERET asserted.
- Reset mid-operation: pending TI, EXL, tick all cleared; intr_vect drops to 0 asynchronously.

## Test plan
- Reset → Status 0x0040_0000, Cause/EPC/BadVAddr/Count/Compare 0, intr_vect 0; Count reads 1 after two clocks, 2 after four.
- MTC0 Status=0x0000_FF01, hw_int=6'b000001 → next cycle Cause.IP10=1, intr_vect=8'h04; set EXL via exception → intr_vect=0.
- cp0w.we, exc=0x04, bd=1, epc=0xBFC0_0100, bva=0x0000_0003 → EPC=0xBFC0_0100, BD=1, ExcCode=4, BadVAddr=3, EXL=1; second exception exc=0x0C epc=0x200 → EPC unchanged, ExcCode=0x0C, BadVAddr unchanged.
- MTC0 Compare=10, Count=0 with IM7/IE set → TI and intr_vect[7] at ~cycle 21; MTC0 Compare=100 → TI cleared next cycle.
- Same cycle cp0w.we=1, eret=1, mtc0_we to EPC=0xDEAD → exception values win, EXL=1, EPC≠0xDEAD.
- ERET with EXL=1 → EXL=0, epc_out unchanged; rst asserted mid-Count → Count 0 immediately.

Source files
------------

// File: rtl/cp0_regs.sv
// cp0_regs: MIPS coprocessor-0 register file (BadVAddr, Count, Compare,
// Status, Cause, EPC) with exception entry, ERET, MTC0/MFC0 and the
// Count/Compare timer interrupt.
//
// cp0w is the exception unit's record, flattened in declaration order:
//   [71] we | [70:66] exc | [65] bd | [64] exl | [63:32] epc | [31:0] bva
// The record's own exl copy is not needed here; Status.EXL is authoritative.
module cp0_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic [71:0] cp0w,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  output logic [7:0]  intr_vect,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  // Unpacked exception record fields
  logic        exc_we;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_bva;
  logic        unused_rec_exl;

  assign exc_we         = cp0w[71];
  assign exc_code       = cp0w[70:66];
  assign exc_bd         = cp0w[65];
  assign unused_rec_exl = cp0w[64];
  assign exc_epc        = cp0w[63:32];
  assign exc_bva        = cp0w[31:0];

  // State
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic        tick_q, tick_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;

  // An MTC0 only takes effect when neither an exception nor ERET retires
  logic mtc0_go;
  assign mtc0_go = mtc0_we & ~exc_we & ~eret;

  // Next-state: timer, then exception > ERET > MTC0 side effects
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q + {31'd0, tick_q};
    tick_d     = ~tick_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    // TI latches on registered equality; a Compare write clears it and wins
    ti_d       = ti_q | (count_q == compare_q);

    if (exc_we) begin
      exccode_d = exc_code;
      exl_d     = 1'b1;
      if (!exl_q) begin
        epc_d = exc_epc;
        bd_d  = exc_bd;
      end
      if (exc_code == EXC_ADEL || exc_code == EXC_ADES) begin
        badvaddr_d = exc_bva;
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (mtc0_go) begin
      case (mtc0_addr)
        REG_COUNT: begin
          count_d = mtc0_data;
          tick_d  = 1'b0;
        end
        REG_COMPARE: begin
          compare_d = mtc0_data;
          ti_d      = 1'b0;
        end
        REG_STATUS: begin
          im_d  = mtc0_data[15:8];
          exl_d = mtc0_data[1];
          ie_d  = mtc0_data[0];
        end
        REG_CAUSE: ip_sw_d = mtc0_data[9:8];
        REG_EPC:   epc_d   = mtc0_data;
        default: ;
      endcase
    end

    // IP7 shares the timer with hw_int[5]; use the updated TI so the timer
    // interrupt and Cause.TI appear at the same edge
    ip_hw_d = {hw_int[5] | ti_d, hw_int[4:0]};
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      tick_q     <= 1'b0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
    end
  end

  // Architectural views of Status and Cause (BEV hard-wired to 1)
  assign status_out = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_out  = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
  assign epc_out    = epc_q;

  // Pending interrupts, masked by IM and gated by IE & ~EXL
  always_comb begin
    intr_vect = 8'h00;
    if (ie_q && !exl_q) begin
      intr_vect = cause_out[15:8] & im_q;
    end
  end

  // MFC0 read mux; unimplemented numbers read zero
  always_comb begin
    mfc0_data = 32'd0;
    case (mfc0_addr)
      REG_BADVADDR: mfc0_data = badvaddr_q;
      REG_COUNT:    mfc0_data = count_q;
      REG_COMPARE:  mfc0_data = compare_q;
      REG_STATUS:   mfc0_data = status_out;
      REG_CAUSE:    mfc0_data = cause_out;
      REG_EPC:      mfc0_data = epc_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: scoreboard bench for cp0_regs. A word-level reference model
// predicts the register file after every clock; a monitor compares on the
// falling edge.
module tb_cp0_regs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]  hw_int;
  logic        cp0w_we, cp0w_bd, cp0w_exl;
  logic [4:0]  cp0w_exc;
  logic [31:0] cp0w_epc, cp0w_bva;
  logic [71:0] cp0w;
  logic        eret, mtc0_we;
  logic [4:0]  mtc0_addr, mfc0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] mfc0_data, epc_out, status_out, cause_out;
  logic [7:0]  intr_vect;

  assign cp0w = {cp0w_we, cp0w_exc, cp0w_bd, cp0w_exl, cp0w_epc, cp0w_bva};

  cp0_regs dut (
    .clk(clk), .rst(rst), .hw_int(hw_int), .cp0w(cp0w), .eret(eret),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data), .intr_vect(intr_vect),
    .epc_out(epc_out), .status_out(status_out), .cause_out(cause_out)
  );

  typedef struct packed {
    logic [5:0]  hw;
    logic        exc_we;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] epc;
    logic [31:0] bva;
    logic        eret;
    logic        mwe;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic [4:0]  raddr;
  } stim_t;

  typedef struct packed {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] rdata;
    logic [7:0]  intr;
    logic [4:0]  raddr;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  int txn = 0;

  // Reference model: architectural words; Count = load value + cycles/2
  logic [31:0] m_status, m_cause, m_epc, m_bva, m_compare, m_base;
  int unsigned m_since;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_since >> 1);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bva;
      5'd9:  return m_count();
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [7:0] m_intr();
    if (m_status[0] && !m_status[1]) return m_cause[15:8] & m_status[15:8];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bva = 0;
    m_compare = 0; m_base = 0; m_since = 0;
  endtask

  // One clock edge of the architecture, using the inputs held this cycle
  task automatic model_clock();
    logic [31:0] cnt;
    logic ti;
    cnt = m_count();
    ti  = m_cause[30] || (cnt == m_compare);
    if (mtc0_we && !cp0w_we && !eret && mtc0_addr == 5'd11) ti = 1'b0;
    m_since++;
    if (cp0w_we) begin
      m_cause[6:2] = cp0w_exc;
      if (!m_status[1]) begin
        m_epc = cp0w_epc;
        m_cause[31] = cp0w_bd;
      end
      m_status[1] = 1'b1;
      if (cp0w_exc == 5'h04 || cp0w_exc == 5'h05) m_bva = cp0w_bva;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end else if (mtc0_we) begin
      case (mtc0_addr)
        5'd9:  begin m_base = mtc0_data; m_since = 0; end
        5'd11: m_compare = mtc0_data;
        5'd12: m_status = (mtc0_data & 32'h0000_FF03) | 32'h0040_0000;
        5'd13: m_cause[9:8] = mtc0_data[9:8];
        5'd14: m_epc = mtc0_data;
        default: ;
      endcase
    end
    m_cause[30] = ti;
    m_cause[15:10] = {hw_int[5] | ti, hw_int[4:0]};
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic apply(input stim_t s);
    hw_int = s.hw; cp0w_we = s.exc_we; cp0w_exc = s.exc; cp0w_bd = s.bd;
    cp0w_exl = m_status[1]; cp0w_epc = s.epc; cp0w_bva = s.bva; eret = s.eret;
    mtc0_we = s.mwe; mtc0_addr = s.maddr; mtc0_data = s.mdata; mfc0_addr = s.raddr;
  endtask

  task automatic push_expect();
    exp_t e;
    e.status = m_status; e.cause = m_cause; e.epc = m_epc;
    e.rdata = m_read(mfc0_addr); e.intr = m_intr(); e.raddr = mfc0_addr;
    sb_q.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(posedge clk); #1;
    model_clock();
    apply(s);
    push_expect();
  endtask

  function automatic stim_t idle(input logic [4:0] raddr);
    stim_t s;
    s = '0;
    s.raddr = raddr;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [4:0] regs [7];
    logic [4:0] codes [6];
    regs  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    codes = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h0C, 5'h0D};
    s.hw     = 6'($urandom);
    s.exc_we = ($urandom_range(0, 15) == 0);
    s.exc    = codes[$urandom_range(0, 5)];
    s.bd     = 1'($urandom);
    s.epc    = $urandom;
    s.bva    = $urandom;
    s.eret   = ($urandom_range(0, 9) == 0);
    s.mwe    = ($urandom_range(0, 3) == 0);
    s.maddr  = regs[$urandom_range(0, 6)];
    s.mdata  = $urandom;
    if (s.maddr == 5'd11) s.mdata = m_count() + 32'($urandom_range(0, 8));
    s.raddr  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 6)];
    return s;
  endfunction

  // Asynchronous reset in the middle of a cycle; outputs must clear at once
  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    apply(idle(5'd9));
    #1;
    chk("rst_count", mfc0_data, 32'd0);
    chk("rst_intr", {24'd0, intr_vect}, 32'd0);
    chk("rst_status", status_out, 32'h0040_0000);
    chk("rst_cause", cause_out, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    push_expect();
  endtask

  // Monitor: compare every presented cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        txn++;
        chk("status_out", status_out, e.status);
        chk("cause_out", cause_out, e.cause);
        chk("epc_out", epc_out, e.epc);
        chk("intr_vect", {24'd0, intr_vect}, {24'd0, e.intr});
        chk($sformatf("mfc0_data[%0d]", e.raddr), mfc0_data, e.rdata);
        $display("txn %0d: mfc0[%0d]=%h intr=%h status=%h cause=%h epc=%h",
                 txn, e.raddr, mfc0_data, intr_vect, status_out, cause_out, epc_out);
      end
    end
  end

  // Stimulus
  initial begin
    stim_t s;
    rst = 1'b1;
    model_reset();
    apply(idle(5'd9));
    #1;
    chk("init_status", status_out, 32'h0040_0000);
    chk("init_cause", cause_out, 32'd0);
    chk("init_epc", epc_out, 32'd0);
    chk("init_count", mfc0_data, 32'd0);
    chk("init_intr", {24'd0, intr_vect}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_expect();

    // Count advances every second clock
    repeat (4) step(idle(5'd9));

    // Clear the TI raised by Count==Compare==0, then enable IM/IE
    s = idle(5'd11); s.mwe = 1; s.maddr = 5'd11; s.mdata = 32'd1000; step(s);
    s = idle(5'd12); s.mwe = 1; s.maddr = 5'd12; s.mdata = 32'h0000_FF01; s.hw = 6'b000001; step(s);
    s = idle(5'd13); s.hw = 6'b000001; step(s); step(s);

    // First exception (AdEL in a delay slot), then a nested one
    s = idle(5'd14); s.hw = 6'b000001; s.exc_we = 1; s.exc = 5'h04; s.bd = 1;
    s.epc = 32'hBFC0_0100; s.bva = 32'h0000_0003; step(s);
    s = idle(5'd8); s.hw = 6'b000001; step(s);
    s = idle(5'd14); s.exc_we = 1; s.exc = 5'h0C; s.epc = 32'h0000_0200; s.bva = 32'h55; step(s);
    step(idle(5'd8)); step(idle(5'd13));

    // ERET clears EXL, EPC untouched
    s = idle(5'd14); s.eret = 1; step(s);
    step(idle(5'd12));

    // Timer: IM7|IE, Count=0, Compare=10, run past equality, then clear TI
    s = idle(5'd12); s.mwe = 1; s.maddr = 5'd12; s.mdata = 32'h0000_8001; step(s);
    s = idle(5'd9);  s.mwe = 1; s.maddr = 5'd9;  s.mdata = 32'd0; step(s);
    s = idle(5'd11); s.mwe = 1; s.maddr = 5'd11; s.mdata = 32'd10; step(s);
    repeat (26) step(idle(5'd13));
    s = idle(5'd11); s.mwe = 1; s.maddr = 5'd11; s.mdata = 32'd100; step(s);
    repeat (3) step(idle(5'd13));

    // Exception, ERET and MTC0 in one cycle: exception wins
    s = idle(5'd14); s.exc_we = 1; s.exc = 5'h08; s.epc = 32'h0000_1234;
    s.eret = 1; s.mwe = 1; s.maddr = 5'd14; s.mdata = 32'h0000_DEAD; step(s);
    step(idle(5'd14)); step(idle(5'd12));

    // MTC0 alongside ERET: ERET applies, MTC0 dropped
    s = idle(5'd14); s.eret = 1; s.mwe = 1; s.maddr = 5'd14; s.mdata = 32'h0000_BEEF; step(s);
    repeat (5) step(idle(5'd9));
    do_reset();
    repeat (3) step(idle(5'd9));

    // Randomized traffic with one reset in the middle
    repeat (250) step(rand_stim());
    do_reset();
    repeat (250) step(rand_stim());
    repeat (2) step(idle(5'd0));

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
